// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the load/store front end: request size encodings,
// the access FSM state type and the alignment rule used to reject requests.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLdRead,
        StStWrite,
        StRmwRead,
        StRmwWrite,
        StDone
    } state_e;

    // Halves must be 2-byte aligned, words 4-byte aligned; size 3 is never legal.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        unique case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lane_extract_merge.sv
// -----------------------------------------------------------------------------
// lane_extract_merge
// Purely combinational lane logic shared by the load and store paths.
//   offset      in   byte offset within the word (addr[1:0])
//   size        in   request size (byte/half/word)
//   sign_ext    in   sign-extend the extracted lane on loads
//   rd_word     in   word read from data memory (load path)
//   load_value  out  selected lane, sign/zero extended
//   merge_word  in   word captured during the read half of a read-modify-write
//   wdata       in   right-justified store data
//   merged_word out  merge_word with the addressed lane replaced by wdata
// -----------------------------------------------------------------------------
module lane_extract_merge
    import mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] rd_word,
    output logic [31:0] load_value,
    input  logic [31:0] merge_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged_word
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [31:0] byte_aligned;
    logic [31:0] half_aligned;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;

    // Big-endian puts offset 0 in the most significant lane, so the shift
    // amount uses the inverted offset.
    always_comb begin
        if (BIG_ENDIAN) begin
            byte_shift = {~offset, 3'b000};
            half_shift = {~offset[1], 4'b0000};
        end else begin
            byte_shift = {offset, 3'b000};
            half_shift = {offset[1], 4'b0000};
        end
    end

    always_comb begin
        byte_aligned = rd_word >> byte_shift;
        half_aligned = rd_word >> half_shift;
        byte_lane    = byte_aligned[7:0];
        half_lane    = half_aligned[15:0];
        load_value   = rd_word;
        unique case (size)
            SZ_BYTE: load_value = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_value = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: load_value = rd_word;
        endcase
    end

    always_comb begin
        byte_mask   = 32'h0000_00ff << byte_shift;
        half_mask   = 32'h0000_ffff << half_shift;
        merged_word = wdata;
        unique case (size)
            SZ_BYTE: merged_word = (merge_word & ~byte_mask) |
                                   ({24'h0, wdata[7:0]} << byte_shift);
            SZ_HALF: merged_word = (merge_word & ~half_mask) |
                                   ({16'h0, wdata[15:0]} << half_shift);
            default: merged_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store front end between the EX/MEM pipeline register and a word-wide
// data memory. Sub-word stores are done as a read-modify-write.
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid         request present (held stable while stall=1)
//   req_write         1 = store, 0 = load
//   req_size          0 byte, 1 half, 2 word, 3 illegal
//   req_signed        sign-extend sub-word loads
//   req_addr          byte address
//   req_wdata         right-justified store data
//   stall             freeze upstream pipeline
//   load_data         extended load result, held until the next load
//   load_valid        one-cycle pulse when load_data is new
//   misalign          request rejected this cycle
//   mem_address       word-aligned memory address
//   mem_write_data    word written to memory
//   MemWrite/MemRead  memory enables (never both set)
//   mem_read_data     combinational memory read data
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  misalign,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  MemWrite,
    output logic                  MemRead,
    input  logic [31:0]           mem_read_data
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic                  write_q;
    logic [31:0]           wdata_q;
    logic [31:0]           merge_q;
    logic [31:0]           load_data_q;

    logic                  req_bad;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [31:0]           load_value;
    logic [31:0]           merged_word;

    assign req_bad   = is_misaligned(req_size, req_addr[1:0]);
    assign accept    = (state_q == StIdle) && req_valid && !req_bad;
    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign load_data = load_data_q;

    lane_extract_merge #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .sign_ext    (signed_q),
        .rd_word     (mem_read_data),
        .load_value  (load_value),
        .merge_word  (merge_q),
        .wdata       (wdata_q),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            merge_q     <= '0;
            load_data_q <= '0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                write_q  <= req_write;
                wdata_q  <= req_wdata;
            end
            if (state_q == StRmwRead) begin
                merge_q <= mem_read_data;
            end
            if (state_q == StLdRead) begin
                load_data_q <= load_value;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        stall          = 1'b0;
        misalign       = 1'b0;
        load_valid     = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_bad) begin
                        misalign = 1'b1;
                    end else begin
                        stall = 1'b1;
                        if (!req_write) begin
                            state_d = StLdRead;
                        end else if (req_size == SZ_WORD) begin
                            state_d = StStWrite;
                        end else begin
                            state_d = StRmwRead;
                        end
                    end
                end
            end
            StLdRead: begin
                stall       = 1'b1;
                MemRead     = 1'b1;
                mem_address = word_addr;
                state_d     = StDone;
            end
            StStWrite: begin
                stall          = 1'b1;
                MemWrite       = 1'b1;
                mem_address    = word_addr;
                mem_write_data = wdata_q;
                state_d        = StDone;
            end
            StRmwRead: begin
                stall       = 1'b1;
                MemRead     = 1'b1;
                mem_address = word_addr;
                state_d     = StRmwWrite;
            end
            StRmwWrite: begin
                stall          = 1'b1;
                MemWrite       = 1'b1;
                mem_address    = word_addr;
                mem_write_data = merged_word;
                state_d        = StDone;
            end
            StDone: begin
                // Upstream advances on this edge; the stale request is not re-accepted.
                load_valid = !write_q;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // stall/misalign decode live inputs, so force them low while reset is held.
        if (!rst_n) begin
            stall    = 1'b0;
            misalign = 1'b0;
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end between the EX/MEM pipeline register and data_memory.
- Turns MIPS lb/lbu/lh/lhu/lw/sb/sh/sw requests into word-wide, word-aligned data_memory accesses.
- Sub-word stores use a two-cycle read-modify-write. Loads are extracted with sign or zero extension.
- Stalls the pipeline while an access is in flight and flags misaligned accesses.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and mem_address.
- BIG_ENDIAN, 1, byte lane order. 1: byte offset 0 = bits [31:24], matching data_memory. 0: byte offset 0 = bits [7:0].

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  memory request present; held stable by upstream until stall=0.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  in  1  load sign-extends when 1 (lb/lh); ignored for stores and words.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  freeze upstream pipeline.
- load_data  out  32  extended load result.
- load_valid  out  1  load_data valid this cycle.
- misalign  out  1  misaligned or illegal request rejected this cycle.
- mem_address  out  ADDR_WIDTH  word-aligned address to data_memory (bits [1:0] = 0).
- mem_write_data  out  32  word written to data_memory.
- MemWrite  out  1  data_memory write enable.
- MemRead  out  1  data_memory read enable.
- mem_read_data  in  32  data_memory read data (combinational).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: stall, load_valid, misalign, MemRead, MemWrite, mem_address, mem_write_data, load_data.
  - Takes effect immediately, mid-operation included. An in-flight RMW or write is aborted with MemWrite dropped before the next edge, so memory is unchanged.
- Misalign check (combinational, IDLE only):
  - size=1 with addr[0]=1, size=2 with addr[1:0]!=0, or size=3.
  - Result: misalign=1 for that cycle, stall=0, no memory access, state stays IDLE.
- FSM states: IDLE, LD_READ, ST_WRITE, RMW_READ, RMW_WRITE, DONE.
- IDLE, with req_valid=1 and the request legal:
  - Register addr, size, signed, wdata; stall=1 combinationally in this cycle.
  - Next state: load -> LD_READ; word store -> ST_WRITE; byte/half store -> RMW_READ.
- LD_READ:
  - MemRead=1, mem_address = {addr[ADDR_WIDTH-1:2], 2'b00}, stall=1.
  - Capture extracted, extended lane into load_data at edge. -> DONE.
- ST_WRITE:
  - MemWrite=1, mem_write_data = wdata, stall=1. -> DONE.
- RMW_READ:
  - MemRead=1, stall=1; capture mem_read_data into merge register. -> RMW_WRITE.
- RMW_WRITE:
  - MemWrite=1, stall=1.
  - mem_write_data = merge register with the addressed lane replaced by wdata[7:0] (byte) or wdata[15:0] (half). -> DONE.
- DONE:
  - stall=0; load_valid=1 if the request was a load. -> IDLE.
  - The request still on req_* is not re-accepted; upstream advances at this edge.
- Latency, cycles from accept to stall=0 inclusive: load 3, word store 3, sub-word store 4.
- MemRead and MemWrite are never both 1. Both are 0 in IDLE and DONE.
- load_data holds its value until the next load completes. load_valid is a one-cycle pulse.
- Lane selection:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Big-endian (BIG_ENDIAN=1): byte 0 = [31:24], half 0 = [31:16].
  - Zero-extend when req_signed=0, sign-extend from bit 7/15 when req_signed=1.
- mem_read_data is sampled only in LD_READ and RMW_READ. Data_memory output while MemRead=0 is ignored.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
  - FSM state encoding.
- One natural sub-module, lane_extract_merge (combinational), holding both:
  - load lane select plus extension.
  - store lane merge.
- Both FSM paths share lane_extract_merge; the FSM stays in mem_access_unit.

Test Plan:
- Loads from word 0x10 preloaded 0x80F17F44, each 3 cycles, load_valid in cycle 3:
  - lb 0x10 -> 0xFFFFFF80.
  - lbu 0x10 -> 0x00000080.
  - lh 0x10 -> 0xFFFF80F1.
  - lhu 0x12 -> 0x00007F44.
  - lb 0x13 -> 0x00000044.
- sb 0x11, wdata 0x000000AB, word 0x10 = 0x80F17F44:
  - MemRead one cycle at 0x10, then MemWrite one cycle with 0x80AB7F44.
  - stall high 3 cycles, low in cycle 4.
- sw 0x14, 0xDEADBEEF: exactly one MemWrite cycle, mem_address=0x14, no MemRead, stall 0 in cycle 3.
- Misaligned requests, each: misalign=1 for 1 cycle, MemRead=MemWrite=0, stall=0, state IDLE:
  - lw 0x12.
  - sh 0x15.
  - size=3.
- sh 0x16 with rst_n pulsed low during RMW_READ: all outputs 0 immediately, word 0x14 unchanged, next request accepted normally.
- Back-to-back sw 0x20 0x12345678 then lw 0x20: load_data=0x12345678, no gap cycle beyond DONE.
